// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-entry first-word-fall-through FIFO between fetch and
// decode, with edge/level load qualification, write pulse, sticky overflow and flush.
module ir_prefetch_queue #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned EDGE_LOAD = 1,
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              load,
   input  logic [DATA_W-1:0] inst_in,
   output logic              load_ready,
   input  logic              issue,
   output logic [DATA_W-1:0] inst_out,
   output logic              inst_valid,
   input  logic              flush,
   output logic              flag,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              load_d;
   logic              wreq;
   logic              push;
   logic              pop;

   assign wreq  = (EDGE_LOAD != 0) ? (load & ~load_d) : load;
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign push  = wreq & ~full & ~flush;
   assign pop   = issue & ~empty & ~flush;

   assign load_ready = ~full;
   assign inst_valid = ~empty;
   assign inst_out   = empty ? '0 : mem[rd_ptr];

   // Storage is deliberately left out of reset; empty masks stale contents.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= inst_in;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         flag     <= 1'b0;
         overflow <= 1'b0;
         load_d   <= 1'b0;
      end else begin
         load_d <= load;
         if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            flag     <= 1'b0;
            overflow <= 1'b0;
         end else begin
            flag <= push;
            if (wreq && full) begin
               overflow <= 1'b1;
            end
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: level-mode (index 0) and edge-mode (index 1) instances checked
// against directed vectors and a queue-based reference model under random stimulus.
module tb_ir_prefetch_queue;

   logic        CLK;
   logic        rst_s   [2];
   logic        load_s  [2];
   logic [15:0] inst_s  [2];
   logic        issue_s [2];
   logic        flush_s [2];
   logic        ready_s [2];
   logic [15:0] out_s   [2];
   logic        valid_s [2];
   logic        flag_s  [2];
   logic        full_s  [2];
   logic        empty_s [2];
   logic [2:0]  count_s [2];
   logic        ov_s    [2];

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [15:0] mq0[$];
   logic [15:0] mq1[$];
   bit          ov_m [2];
   bit          fl_m [2];
   bit          ld_m [2];

   typedef struct {
      int          m;
      bit          rst_n;
      bit          load;
      bit          issue;
      bit          flush;
      logic [15:0] inst;
      int          cnt;
      logic [15:0] out;
      bit          full;
      bit          ov;
      bit          flag;
      string       name;
   } vec_t;

   vec_t vecs[$];

   ir_prefetch_queue #(.DATA_W(16), .DEPTH(4), .EDGE_LOAD(0)) u_lvl (
      .CLK        (CLK),
      .RST_N      (rst_s[0]),
      .load       (load_s[0]),
      .inst_in    (inst_s[0]),
      .load_ready (ready_s[0]),
      .issue      (issue_s[0]),
      .inst_out   (out_s[0]),
      .inst_valid (valid_s[0]),
      .flush      (flush_s[0]),
      .flag       (flag_s[0]),
      .full       (full_s[0]),
      .empty      (empty_s[0]),
      .count      (count_s[0]),
      .overflow   (ov_s[0])
   );

   ir_prefetch_queue #(.DATA_W(16), .DEPTH(4), .EDGE_LOAD(1)) u_edge (
      .CLK        (CLK),
      .RST_N      (rst_s[1]),
      .load       (load_s[1]),
      .inst_in    (inst_s[1]),
      .load_ready (ready_s[1]),
      .issue      (issue_s[1]),
      .inst_out   (out_s[1]),
      .inst_valid (valid_s[1]),
      .flush      (flush_s[1]),
      .flag       (flag_s[1]),
      .full       (full_s[1]),
      .empty      (empty_s[1]),
      .count      (count_s[1]),
      .overflow   (ov_s[1])
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic void add(input int m, input bit r, input bit ld, input bit is,
                               input bit fl, input logic [15:0] din, input int cnt,
                               input logic [15:0] dout, input bit fu, input bit ov,
                               input bit fg, input string nm);
      vec_t v;
      v.m = m; v.rst_n = r; v.load = ld; v.issue = is; v.flush = fl; v.inst = din;
      v.cnt = cnt; v.out = dout; v.full = fu; v.ov = ov; v.flag = fg; v.name = nm;
      vecs.push_back(v);
   endfunction

   task automatic step_model(input int m);
      logic [15:0] q[$];
      bit wreq;
      bit is_full;
      bit is_empty;
      if (m == 0) q = mq0;
      else        q = mq1;
      if (!rst_s[m]) begin
         q.delete();
         ov_m[m] = 0;
         fl_m[m] = 0;
         ld_m[m] = 0;
      end else begin
         wreq     = load_s[m] && (m == 0 || !ld_m[m]);
         is_full  = (q.size() == 4);
         is_empty = (q.size() == 0);
         if (flush_s[m]) begin
            q.delete();
            ov_m[m] = 0;
            fl_m[m] = 0;
         end else begin
            if (wreq && is_full) ov_m[m] = 1;
            fl_m[m] = wreq && !is_full;
            if (issue_s[m] && !is_empty) void'(q.pop_front());
            if (wreq && !is_full) q.push_back(inst_s[m]);
         end
         ld_m[m] = load_s[m];
      end
      if (m == 0) mq0 = q;
      else        mq1 = q;
   endtask

   task automatic check_dut(input int m);
      logic [15:0] q[$];
      logic [24:0] got;
      logic [24:0] exp;
      int n;
      if (m == 0) q = mq0;
      else        q = mq1;
      n   = q.size();
      got = {count_s[m], out_s[m], valid_s[m], empty_s[m], full_s[m], ready_s[m],
             flag_s[m], ov_s[m]};
      exp = {3'(n), (n != 0) ? q[0] : 16'h0, n != 0, n == 0, n == 4, n != 4,
             fl_m[m], ov_m[m]};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL model_dut%0d t=%0t got=%h exp=%h (cnt,out,val,emp,full,rdy,flag,ov)",
                  m, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      step_model(0);
      step_model(1);
      #1;
      check_dut(0);
      check_dut(1);
      @(negedge CLK);
   endtask

   task automatic idle(input int m);
      rst_s[m]   = 1'b1;
      load_s[m]  = 1'b0;
      issue_s[m] = 1'b0;
      flush_s[m] = 1'b0;
      inst_s[m]  = 16'h0;
   endtask

   initial begin
      logic [15:0] w;
      logic [23:0] got_v;
      logic [23:0] exp_v;

      // Edge-mode directed vectors
      add(1, 1, 1, 0, 0, 16'hA123, 1, 16'hA123, 0, 0, 1, "e_first_write");
      add(1, 1, 0, 0, 0, 16'h0000, 1, 16'hA123, 0, 0, 0, "e_flag_once");
      add(1, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "e_issue");
      for (int k = 0; k < 5; k++)
         add(1, 1, 1, 0, 0, 16'h0001, 1, 16'h0001, 0, 0, k == 0, "e_hold_load");
      add(1, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "e_drain");
      add(1, 1, 1, 0, 0, 16'hB001, 1, 16'hB001, 0, 0, 1, "e_fill1");
      add(1, 1, 0, 0, 0, 16'h0000, 1, 16'hB001, 0, 0, 0, "e_fill1_gap");
      add(1, 1, 1, 0, 0, 16'hB002, 2, 16'hB001, 0, 0, 1, "e_fill2");
      add(1, 1, 0, 0, 0, 16'h0000, 2, 16'hB001, 0, 0, 0, "e_fill2_gap");
      add(1, 1, 1, 0, 0, 16'hB003, 3, 16'hB001, 0, 0, 1, "e_fill3");
      add(1, 1, 0, 0, 0, 16'h0000, 3, 16'hB001, 0, 0, 0, "e_fill3_gap");
      add(1, 1, 1, 1, 1, 16'hB004, 0, 16'h0000, 0, 0, 0, "e_flush_priority");
      add(1, 1, 1, 0, 0, 16'hB005, 0, 16'h0000, 0, 0, 0, "e_no_retrigger");
      add(1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "e_after_flush");
      add(1, 0, 1, 0, 0, 16'hC001, 0, 16'h0000, 0, 0, 0, "e_rst_load_high");
      add(1, 1, 1, 0, 0, 16'hC001, 1, 16'hC001, 0, 0, 1, "e_post_rst_write");
      add(1, 1, 1, 0, 0, 16'hC002, 1, 16'hC001, 0, 0, 0, "e_post_rst_hold");

      // Level-mode directed vectors
      add(0, 1, 1, 0, 0, 16'h1000, 1, 16'h1000, 0, 0, 1, "l_w0");
      add(0, 1, 1, 0, 0, 16'h1001, 2, 16'h1000, 0, 0, 1, "l_w1");
      add(0, 1, 1, 0, 0, 16'h1002, 3, 16'h1000, 0, 0, 1, "l_w2");
      add(0, 1, 1, 0, 0, 16'h1003, 4, 16'h1000, 1, 0, 1, "l_w3_full");
      add(0, 1, 1, 0, 0, 16'h1004, 4, 16'h1000, 1, 1, 0, "l_overflow");
      add(0, 1, 0, 1, 0, 16'h0000, 3, 16'h1001, 0, 1, 0, "l_issue1");
      add(0, 1, 0, 1, 0, 16'h0000, 2, 16'h1002, 0, 1, 0, "l_issue2");
      add(0, 1, 0, 1, 0, 16'h0000, 1, 16'h1003, 0, 1, 0, "l_issue3");
      add(0, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, "l_issue4_empty");
      add(0, 1, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, "l_flush_clr_ov");
      for (int k = 0; k < 10; k++) begin
         w = 16'h3000 + 16'(k);
         add(0, 1, 1, k >= 2, 0, w, (k == 0) ? 1 : 2,
             (k < 2) ? 16'h3000 : 16'h3000 + 16'(k - 1), 0, 0, 1, "l_wrap");
      end
      add(0, 1, 0, 1, 0, 16'h0000, 1, 16'h3009, 0, 0, 0, "l_wrap_drain1");
      add(0, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "l_wrap_drain2");
      for (int k = 0; k < 3; k++)
         add(0, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "l_issue_empty");
      add(0, 1, 1, 0, 0, 16'h2001, 1, 16'h2001, 0, 0, 1, "l_pre_rst1");
      add(0, 1, 1, 0, 0, 16'h2002, 2, 16'h2001, 0, 0, 1, "l_pre_rst2");
      add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "l_mid_reset");
      add(0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "l_post_reset");

      // Reset both instances
      for (int m = 0; m < 2; m++) begin
         idle(m);
         rst_s[m] = 1'b0;
      end
      tick();
      tick();
      for (int m = 0; m < 2; m++) idle(m);

      foreach (vecs[i]) begin
         idle(0);
         idle(1);
         rst_s[vecs[i].m]   = vecs[i].rst_n;
         load_s[vecs[i].m]  = vecs[i].load;
         issue_s[vecs[i].m] = vecs[i].issue;
         flush_s[vecs[i].m] = vecs[i].flush;
         inst_s[vecs[i].m]  = vecs[i].inst;
         tick();
         got_v = {count_s[vecs[i].m], out_s[vecs[i].m], full_s[vecs[i].m],
                  ov_s[vecs[i].m], flag_s[vecs[i].m], valid_s[vecs[i].m],
                  ready_s[vecs[i].m]};
         exp_v = {3'(vecs[i].cnt), vecs[i].out, vecs[i].full, vecs[i].ov, vecs[i].flag,
                  vecs[i].cnt != 0, !vecs[i].full};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s vec%0d got=%h exp=%h (cnt,out,full,ov,flag,val,rdy)",
                     vecs[i].name, i, got_v, exp_v);
         end
      end

      // Random stimulus against the model
      for (int c = 0; c < 3000; c++) begin
         for (int m = 0; m < 2; m++) begin
            rst_s[m]   = ($urandom_range(0, 199) != 0);
            flush_s[m] = ($urandom_range(0, 29) == 0);
            load_s[m]  = ($urandom_range(0, 9) < 6);
            issue_s[m] = ($urandom_range(0, 9) < 4);
            inst_s[m]  = 16'($urandom);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
